// File: rtl/iterative_shift_right.sv
// iterative_shift_right: multi-cycle SRL/SRA unit shifting one bit per clock with start/busy/done handshake
module iterative_shift_right #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] In,
    input  logic [SHW-1:0]   ShAmt,
    input  logic             Arith,
    input  logic             Flush,
    output logic [WIDTH-1:0] Out,
    output logic             Busy,
    output logic             Done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [SHW-1:0] ONE = SHW'(1);

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;
    logic             arith;
    logic [WIDTH-1:0] shifted;

    assign shifted = {arith & acc[WIDTH-1], acc[WIDTH-1:1]};
    assign Busy    = state != IDLE;
    assign Done    = state == DONE;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            arith <= 1'b0;
            Out   <= '0;
        end else if (Flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    acc   <= In;
                    cnt   <= ShAmt;
                    arith <= Arith;
                    if (ShAmt == '0) begin
                        state <= DONE;
                        Out   <= In;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= shifted;
                    cnt <= cnt - ONE;
                    // Out is captured on the final shift so it is valid for the whole DONE cycle
                    if (cnt == ONE) begin
                        state <= DONE;
                        Out   <= shifted;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iterative_shift_right.sv
// tb_iterative_shift_right: directed and randomized checks of the iterative right shifter against arithmetic shifts
module tb_iterative_shift_right;
    logic        Clk, Reset, Start, Arith, Flush, Busy, Done;
    logic [31:0] In, Out;
    logic [4:0]  ShAmt;
    int          n_assert, n_fail;

    iterative_shift_right #(.WIDTH(32), .SHW(5)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .In(In), .ShAmt(ShAmt),
        .Arith(Arith), .Flush(Flush), .Out(Out), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation: latency, Busy during flight, Out hold mid-shift, result, and Start ignored while busy
    task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] sh, input logic ar);
        logic [31:0] exp, prev;
        int k;
        exp  = ar ? 32'($signed(a) >>> sh) : (a >> sh);
        @(negedge Clk);
        prev  = Out;
        In    = a;
        ShAmt = sh;
        Arith = ar;
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        In    = $urandom;
        ShAmt = 5'($urandom);
        Arith = 1'($urandom);
        k = 0;
        @(negedge Clk);
        while (!Done && k < 40) begin
            check({tag, "_busy"}, 32'(Busy), 32'd1);
            check({tag, "_hold"}, Out, prev);
            Start = 1'($urandom);
            In    = $urandom;
            @(negedge Clk);
            k++;
        end
        check({tag, "_latency"}, 32'(k + 1), 32'(sh) + 32'd1);
        check({tag, "_busy_done"}, 32'(Busy), 32'd1);
        check({tag, "_out"}, Out, exp);
        Start = 1'b1;
        In    = 32'hDEADBEEF;
        ShAmt = 5'd0;
        @(negedge Clk);
        Start = 1'b0;
        check({tag, "_done_low"}, 32'(Done), 32'd0);
        check({tag, "_busy_low"}, 32'(Busy), 32'd0);
        check({tag, "_out_kept"}, Out, exp);
    endtask

    initial begin
        logic [31:0] prev;
        int dones;
        n_assert = 0;
        n_fail   = 0;
        Clk   = 1'b0;
        Reset = 1'b1;
        Start = 1'b0;
        Flush = 1'b0;
        Arith = 1'b0;
        In    = '0;
        ShAmt = '0;
        #1;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_out", Out, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        run_op("srl_basic", 32'h80000000, 5'd4, 1'b0);
        check("srl_basic_val", Out, 32'h08000000);
        run_op("sra_max", 32'h80000000, 5'd31, 1'b1);
        check("sra_max_val", Out, 32'hFFFFFFFF);
        run_op("srl_max", 32'h80000000, 5'd31, 1'b0);
        check("srl_max_val", Out, 32'h00000001);
        run_op("zero", 32'h12345678, 5'd0, 1'b0);
        check("zero_val", Out, 32'h12345678);

        prev = Out;
        @(negedge Clk);
        In    = 32'hF0F0F0F0;
        ShAmt = 5'd10;
        Arith = 1'b1;
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush_busy", 32'(Busy), 32'd0);
        check("flush_done", 32'(Done), 32'd0);
        check("flush_out", Out, prev);
        dones = 0;
        repeat (14) begin
            @(negedge Clk);
            dones += int'(Done);
        end
        check("flush_no_done", 32'(dones), 32'd0);
        run_op("after_flush", 32'hF0F0F0F0, 5'd4, 1'b1);
        check("after_flush_val", Out, 32'hFF0F0F0F);

        prev = Out;
        @(negedge Clk);
        In    = 32'hAAAA5555;
        ShAmt = 5'd0;
        Start = 1'b1;
        Flush = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Flush = 1'b0;
        check("flush_start_busy", 32'(Busy), 32'd0);
        check("flush_start_done", 32'(Done), 32'd0);
        @(negedge Clk);
        check("flush_start_out", Out, prev);

        @(negedge Clk);
        In    = 32'hFFFF0000;
        ShAmt = 5'd8;
        Arith = 1'b0;
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(Busy), 32'd0);
        check("rst_mid_done", 32'(Done), 32'd0);
        check("rst_mid_out", Out, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        dones = 0;
        repeat (12) begin
            @(negedge Clk);
            dones += int'(Done);
        end
        check("rst_mid_no_done", 32'(dones), 32'd0);
        run_op("after_rst", 32'hFFFF0000, 5'd8, 1'b1);
        check("after_rst_val", Out, 32'hFFFFFF00);

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            run_op("rand", $urandom, 5'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
